// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between the
// instruction-fetch port (I) and the load/store port (D). All outputs are registered.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : gBadLatency
            $fatal(1, "mem_port_arbiter: MEM_LATENCY must be within 1..7");
        end
        if (DATA_W != 32) begin : gBadWidth
            $fatal(1, "mem_port_arbiter: DATA_W must be 32 to match the 4-bit byte strobe");
        end
    endgenerate

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

    stateT             state, stateNext;
    logic              lastGrantD, lastGrantDNext;
    logic              grantD, grantDNext;
    logic              latWe, latWeNext;
    logic [2:0]        cnt, cntNext;
    logic              pickD;
    logic              memEnNext, memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic [3:0]        memWstrbNext;
    logic              ifReadyNext, dReadyNext, busyNext;
    logic [DATA_W-1:0] ifRdataNext, dRdataNext;

    always_comb begin
        stateNext      = state;
        lastGrantDNext = lastGrantD;
        grantDNext     = grantD;
        latWeNext      = latWe;
        cntNext        = cnt;
        pickD          = 1'b0;
        memEnNext      = 1'b0;
        memWeNext      = 1'b0;
        memAddrNext    = '0;
        memWdataNext   = '0;
        memWstrbNext   = 4'b0000;
        ifReadyNext    = 1'b0;
        dReadyNext     = 1'b0;
        ifRdataNext    = if_rdata;
        dRdataNext     = d_rdata;

        case (state)
            IDLE: begin
                pickD = d_req && (!if_req || !lastGrantD);
                // A req still high during its own ready pulse belongs to the finished access.
                if ((if_req || d_req) && !if_ready && !d_ready) begin
                    stateNext      = ISSUE;
                    grantDNext     = pickD;
                    lastGrantDNext = pickD;
                    latWeNext      = pickD && d_we;
                    memEnNext      = 1'b1;
                    memWeNext      = pickD && d_we;
                    memAddrNext    = pickD ? d_addr : if_addr;
                    memWdataNext   = (pickD && d_we) ? d_wdata : '0;
                    memWstrbNext   = (pickD && d_we) ? d_wstrb : 4'b0000;
                end
            end
            ISSUE: begin
                if (latWe) begin
                    stateNext = RESP;
                end else begin
                    cntNext   = LAT_LOAD;
                    stateNext = (LAT_LOAD == 3'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cntNext = cnt - 3'd1;
                if (cnt == 3'd1) stateNext = RESP;
            end
            RESP: begin
                stateNext = IDLE;
                if (grantD) begin
                    dReadyNext = 1'b1;
                    if (!latWe) dRdataNext = mem_rdata;
                end else begin
                    ifReadyNext = 1'b1;
                    ifRdataNext = mem_rdata;
                end
            end
            default: stateNext = IDLE;
        endcase

        // The ready cycle still belongs to the access, so busy covers it too.
        busyNext = (stateNext != IDLE) || ifReadyNext || dReadyNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lastGrantD <= 1'b0;
            grantD     <= 1'b0;
            latWe      <= 1'b0;
            cnt        <= 3'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= stateNext;
            lastGrantD <= lastGrantDNext;
            grantD     <= grantDNext;
            latWe      <= latWeNext;
            cnt        <= cntNext;
            mem_en     <= memEnNext;
            mem_we     <= memWeNext;
            mem_addr   <= memAddrNext;
            mem_wdata  <= memWdataNext;
            mem_wstrb  <= memWstrbNext;
            if_ready   <= ifReadyNext;
            d_ready    <= dReadyNext;
            if_rdata   <= ifRdataNext;
            d_rdata    <= dRdataNext;
            busy       <= busyNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LATENCY=1, instance 1 uses MEM_LATENCY=4,
// each attached to its own behavioural RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq [2];
    logic [31:0] ifAddr [2];
    logic        ifReady [2];
    logic [31:0] ifRdata [2];
    logic        dReq [2];
    logic        dWe [2];
    logic [31:0] dAddr [2];
    logic [31:0] dWdata [2];
    logic [3:0]  dWstrb [2];
    logic        dReady [2];
    logic [31:0] dRdata [2];
    logic        memEn [2];
    logic        memWe [2];
    logic [31:0] memAddr [2];
    logic [31:0] memWdata [2];
    logic [3:0]  memWstrb [2];
    logic [31:0] memRdata [2];
    logic        busy [2];

    int nCmp = 0;
    int nErr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) uLat1 (
        .clk(clk), .rst(rst),
        .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_ready(ifReady[0]), .if_rdata(ifRdata[0]),
        .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]), .d_wstrb(dWstrb[0]),
        .d_ready(dReady[0]), .d_rdata(dRdata[0]),
        .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
        .mem_wstrb(memWstrb[0]), .mem_rdata(memRdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) uLat4 (
        .clk(clk), .rst(rst),
        .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_ready(ifReady[1]), .if_rdata(ifRdata[1]),
        .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]), .d_wstrb(dWstrb[1]),
        .d_ready(dReady[1]), .d_rdata(dRdata[1]),
        .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
        .mem_wstrb(memWstrb[1]), .mem_rdata(memRdata[1]), .busy(busy[1])
    );

    // ---------------- behavioural RAM ----------------
    logic [31:0] memArr [2][256];
    bit          memWr [2][256];
    logic [31:0] pipe [2][8];

    function automatic logic [31:0] initVal(input int i);
        case (i)
            4:       return 32'h0051_0113;
            8:       return 32'h1234_5678;
            9:       return 32'h0BAD_0BAD;
            10:      return 32'h0040_0513;
            16:      return 32'h0000_0093;
            192:     return 32'hCAFE_F00D;
            default: return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] memRead(input int p, input int i);
        return memWr[p][i] ? memArr[p][i] : initVal(i);
    endfunction

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (memEn[p] && memWe[p]) begin
                memArr[p][memAddr[p][9:2]] <= merge(memRead(p, int'(memAddr[p][9:2])),
                                                    memWdata[p], memWstrb[p]);
                memWr[p][memAddr[p][9:2]]  <= 1'b1;
            end
            // Outside the valid slot the RAM drives junk so mistimed captures show up.
            pipe[p][0] <= (memEn[p] && !memWe[p]) ? memRead(p, int'(memAddr[p][9:2])) : $urandom;
            for (int k = 1; k < 8; k++) pipe[p][k] <= pipe[p][k-1];
        end
    end

    assign memRdata[0] = pipe[0][0];
    assign memRdata[1] = pipe[1][3];

    // ---------------- clock / reset / driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleInputs();
        for (int p = 0; p < 2; p++) begin
            ifReq[p] = 1'b0; ifAddr[p] = '0; dReq[p] = 1'b0; dWe[p] = 1'b0;
            dAddr[p] = '0; dWdata[p] = '0; dWstrb[p] = 4'b0000;
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        for (int p = 0; p < 2; p++) begin
            nCmp++;
            if ({memEn[p], memWe[p], memAddr[p], memWdata[p], memWstrb[p]} !== 70'h0) begin
                nErr++; $display("FAIL reset_mem_bus[%0d]: got en=%b we=%b addr=%h wdata=%h wstrb=%b want all 0",
                                 p, memEn[p], memWe[p], memAddr[p], memWdata[p], memWstrb[p]);
            end
            nCmp++;
            if ({ifReady[p], dReady[p], busy[p]} !== 3'b000) begin
                nErr++; $display("FAIL reset_ready_busy[%0d]: got %b%b%b want 000", p, ifReady[p], dReady[p], busy[p]);
            end
            nCmp++;
            if ({ifRdata[p], dRdata[p]} !== 64'h0) begin
                nErr++; $display("FAIL reset_rdata[%0d]: got if=%h d=%h want 0", p, ifRdata[p], dRdata[p]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        ifAddr[0] = 32'h0000_0010;
        ifReq[0]  = 1'b1;
        nCmp++;
        if (busy[0] !== 1'b0) begin nErr++; $display("FAIL fetch_busy_t: got %b want 0", busy[0]); end
        tick();
        nCmp++;
        if ({memEn[0], memWe[0], memWstrb[0], memAddr[0]} !== {1'b1, 1'b0, 4'h0, 32'h10}) begin
            nErr++; $display("FAIL fetch_issue: got en=%b we=%b wstrb=%b addr=%h want 1 0 0000 00000010",
                             memEn[0], memWe[0], memWstrb[0], memAddr[0]);
        end
        nCmp++;
        if (busy[0] !== 1'b1) begin nErr++; $display("FAIL fetch_busy_t1: got %b want 1", busy[0]); end
        tick();
        nCmp++;
        if ({memEn[0], ifReady[0], busy[0]} !== 3'b001) begin
            nErr++; $display("FAIL fetch_t2: got en/ifready/busy=%b%b%b want 001", memEn[0], ifReady[0], busy[0]);
        end
        tick();
        nCmp++;
        if ({ifReady[0], dReady[0], busy[0]} !== 3'b101 || ifRdata[0] !== 32'h0051_0113) begin
            nErr++; $display("FAIL fetch_ready: got ifready/dready/busy=%b%b%b rdata=%h want 101 00510113",
                             ifReady[0], dReady[0], busy[0], ifRdata[0]);
        end
        ifReq[0] = 1'b0;
        tick();
        nCmp++;
        if ({ifReady[0], busy[0]} !== 2'b00) begin
            nErr++; $display("FAIL fetch_after: got ifready/busy=%b%b want 00", ifReady[0], busy[0]);
        end
    endtask

    task automatic test_tie_store_then_fetch();
        applyReset();
        ifReq[0] = 1'b1; ifAddr[0] = 32'h40;
        dReq[0]  = 1'b1; dWe[0] = 1'b1; dAddr[0] = 32'h100; dWdata[0] = 32'hDEAD_BEEF; dWstrb[0] = 4'b1111;
        tick();
        nCmp++;
        if ({memEn[0], memWe[0], memWstrb[0], memAddr[0], memWdata[0]} !== {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin
            nErr++; $display("FAIL tie_d_issue: got en=%b we=%b wstrb=%b addr=%h wdata=%h want 1 1 1111 00000100 deadbeef",
                             memEn[0], memWe[0], memWstrb[0], memAddr[0], memWdata[0]);
        end
        tick();
        tick();
        nCmp++;
        if ({dReady[0], ifReady[0]} !== 2'b10) begin
            nErr++; $display("FAIL tie_d_ready: got dready/ifready=%b%b want 10", dReady[0], ifReady[0]);
        end
        dReq[0] = 1'b0; dWe[0] = 1'b0;
        tick();
        nCmp++;
        if (memEn[0] !== 1'b0) begin nErr++; $display("FAIL tie_gap: got mem_en=%b want 0", memEn[0]); end
        tick();
        nCmp++;
        if ({memEn[0], memWe[0], memAddr[0]} !== {1'b1, 1'b0, 32'h40}) begin
            nErr++; $display("FAIL tie_i_issue: got en=%b we=%b addr=%h want 1 0 00000040", memEn[0], memWe[0], memAddr[0]);
        end
        tick();
        tick();
        nCmp++;
        if (ifReady[0] !== 1'b1 || ifRdata[0] !== initVal(16)) begin
            nErr++; $display("FAIL tie_i_ready: got ifready=%b rdata=%h want 1 %h", ifReady[0], ifRdata[0], initVal(16));
        end
        ifReq[0] = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic [31:0] exp_q[$];
        int grants = 0, lastGrant = 0, nI = 0, nD = 0;
        applyReset();
        for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 32'h200 : 32'h80);
        ifReq[0] = 1'b1; ifAddr[0] = 32'h80;
        dReq[0]  = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h200;
        for (int c = 0; c < 80 && grants < 8; c++) begin
            tick();
            if (ifReady[0]) nI++;
            if (dReady[0]) nD++;
            if (memEn[0]) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                nCmp++;
                if (memAddr[0] !== e) begin
                    nErr++; $display("FAIL fair_order[%0d]: got addr=%h want %h", grants, memAddr[0], e);
                end
                if (grants > 0) begin
                    nCmp++;
                    if (cyc - lastGrant != 4) begin
                        nErr++; $display("FAIL fair_gap[%0d]: got %0d cycles want 4", grants, cyc - lastGrant);
                    end
                end
                lastGrant = cyc;
                grants++;
            end
        end
        nCmp++;
        if (grants != 8) begin nErr++; $display("FAIL fair_timeout: got %0d grants want 8", grants); end
        tick();
        tick();
        if (ifReady[0]) nI++;
        if (dReady[0]) nD++;
        ifReq[0] = 1'b0; dReq[0] = 1'b0;
        tick();
        tick();
        nCmp++;
        if (nI != 4 || nD != 4) begin nErr++; $display("FAIL fair_readies: got I=%0d D=%0d want 4 4", nI, nD); end
    endtask

    task automatic test_load_latency4();
        int nEn = 0;
        dAddr[1] = 32'h20; dWe[1] = 1'b0; dReq[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (memEn[1]) nEn++;
            nCmp++;
            if (k == 6) begin
                if (dReady[1] !== 1'b1 || dRdata[1] !== 32'h1234_5678) begin
                    nErr++; $display("FAIL lat4_ready: got dready=%b rdata=%h want 1 12345678", dReady[1], dRdata[1]);
                end
                dReq[1] = 1'b0;
            end else if (dReady[1] !== 1'b0) begin
                nErr++; $display("FAIL lat4_no_ready[t+%0d]: got dready=%b want 0", k, dReady[1]);
            end
        end
        nCmp++;
        if (nEn != 1) begin nErr++; $display("FAIL lat4_mem_en_count: got %0d want 1", nEn); end
    endtask

    task automatic test_byte_store();
        for (int a = 0; a < 3; a++) begin
            logic        we;
            logic [31:0] expR;
            we   = (a == 1);
            expR = (a == 2) ? 32'hCAAB_F00D : 32'hCAFE_F00D;
            dAddr[0] = 32'h300; dWe[0] = we; dWdata[0] = 32'h00AB_0000; dWstrb[0] = 4'b0100; dReq[0] = 1'b1;
            tick();
            nCmp++;
            if (memEn[0] !== 1'b1 || memWstrb[0] !== (we ? 4'b0100 : 4'b0000) || memWe[0] !== we) begin
                nErr++; $display("FAIL bstore_issue[%0d]: got en=%b we=%b wstrb=%b want 1 %b %b",
                                 a, memEn[0], memWe[0], memWstrb[0], we, we ? 4'b0100 : 4'b0000);
            end
            tick();
            nCmp++;
            if (memWstrb[0] !== 4'b0000 || memEn[0] !== 1'b0) begin
                nErr++; $display("FAIL bstore_strobe_len[%0d]: got en=%b wstrb=%b want 0 0000", a, memEn[0], memWstrb[0]);
            end
            tick();
            nCmp++;
            if (dReady[0] !== 1'b1 || dRdata[0] !== expR) begin
                nErr++; $display("FAIL bstore_ready[%0d]: got dready=%b rdata=%h want 1 %h", a, dReady[0], dRdata[0], expR);
            end
            dReq[0] = 1'b0; dWe[0] = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        dAddr[1] = 32'h24; dWe[1] = 1'b0; dReq[1] = 1'b1;
        tick();
        tick();
        tick();
        nCmp++;
        if (busy[1] !== 1'b1) begin nErr++; $display("FAIL midrst_busy: got %b want 1", busy[1]); end
        rst = 1'b1;
        tick();
        nCmp++;
        if ({memEn[1], memWe[1], memAddr[1], memWdata[1], memWstrb[1], ifReady[1], dReady[1], busy[1]} !== 73'h0 ||
            {ifRdata[1], dRdata[1]} !== 64'h0) begin
            nErr++; $display("FAIL midrst_outputs: got en=%b addr=%h dready=%b busy=%b ifr=%h dr=%h want all 0",
                             memEn[1], memAddr[1], dReady[1], busy[1], ifRdata[1], dRdata[1]);
        end
        rst = 1'b0; dReq[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            nCmp++;
            if (dReady[1] !== 1'b0 || memEn[1] !== 1'b0) begin
                nErr++; $display("FAIL midrst_quiet[%0d]: got dready=%b mem_en=%b want 0 0", k, dReady[1], memEn[1]);
            end
        end
        ifAddr[1] = 32'h28; ifReq[1] = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        nCmp++;
        if (ifReady[1] !== 1'b1 || ifRdata[1] !== 32'h0040_0513) begin
            nErr++; $display("FAIL midrst_refetch: got ifready=%b rdata=%h want 1 00400513", ifReady[1], ifRdata[1]);
        end
        ifReq[1] = 1'b0;
        tick();
    endtask

    // Transaction-level reference: grant order from the round-robin rule, completion
    // cycle from the access duration, data from a private copy of the RAM contents.
    task automatic test_random(input int p, input int rounds);
        logic [31:0] refMem [256];
        logic [31:0] curI, curD, expI, expD, wd;
        logic [3:0]  st;
        bit          lastD, useI, useD, firstD, dW, gotI, gotD, done, isD;
        int          lat, t, sample, rdy, rdyI, rdyD, iIdx, dIdx, mode;
        lat = (p == 0) ? 1 : 4;
        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        applyReset();
        lastD = 1'b0; curI = '0; curD = '0;
        for (int r = 0; r < rounds; r++) begin
            repeat ($urandom_range(1, 3)) tick();
            mode = $urandom_range(0, 2);
            useI = (mode != 1); useD = (mode != 0);
            iIdx = $urandom_range(100, 191);
            dIdx = ($urandom_range(0, 3) == 0) ? iIdx : $urandom_range(100, 191);
            dW = $urandom_range(0, 1); wd = $urandom; st = 4'($urandom_range(0, 15));
            firstD = (useI && useD) ? !lastD : useD;
            t = cyc; sample = t; rdyI = -1; rdyD = -1; expI = curI; expD = curD;
            for (int k = 0; k < 2; k++) begin
                if (k == 1 && !(useI && useD)) break;
                isD = (k == 0) ? firstD : !firstD;
                rdy = sample + ((isD && dW) ? 3 : 2 + lat);
                sample = rdy + 1;
                lastD = isD;
                if (isD) begin
                    rdyD = rdy;
                    if (dW) refMem[dIdx] = merge(refMem[dIdx], wd, st);
                    else curD = refMem[dIdx];
                    expD = curD;
                end else begin
                    rdyI = rdy; curI = refMem[iIdx]; expI = curI;
                end
            end
            ifReq[p] = useI; ifAddr[p] = ($urandom & 32'hFFFF_FC00) | 32'(iIdx << 2);
            dReq[p] = useD; dWe[p] = dW; dAddr[p] = ($urandom & 32'hFFFF_FC00) | 32'(dIdx << 2);
            dWdata[p] = wd; dWstrb[p] = st;
            gotI = 1'b0; gotD = 1'b0; done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                tick();
                if (ifReady[p]) begin
                    nCmp++;
                    if (!useI || gotI || cyc != rdyI || ifRdata[p] !== expI) begin
                        nErr++; $display("FAIL rand_if[%0d.%0d]: got cyc=%0d rdata=%h want cyc=%0d rdata=%h (requested=%b)",
                                         p, r, cyc, ifRdata[p], rdyI, expI, useI);
                    end
                    gotI = 1'b1; ifReq[p] = 1'b0;
                end
                if (dReady[p]) begin
                    nCmp++;
                    if (!useD || gotD || cyc != rdyD || dRdata[p] !== expD) begin
                        nErr++; $display("FAIL rand_d[%0d.%0d]: got cyc=%0d rdata=%h want cyc=%0d rdata=%h (requested=%b)",
                                         p, r, cyc, dRdata[p], rdyD, expD, useD);
                    end
                    gotD = 1'b1; dReq[p] = 1'b0; dWe[p] = 1'b0;
                end
                done = (gotI || !useI) && (gotD || !useD);
            end
            if (!done) begin
                nCmp++; nErr++;
                $display("FAIL rand_timeout[%0d.%0d]: got ifdone=%b ddone=%b want both served", p, r, gotI, gotD);
                ifReq[p] = 1'b0; dReq[p] = 1'b0;
            end
        end
        tick();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single_fetch();
        test_tie_store_then_fetch();
        test_fairness();
        test_load_latency4();
        test_byte_store();
        test_reset_mid_wait();
        test_random(0, 30);
        test_random(1, 30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion within time limit want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
